// File: rtl/fsmserial_tx.sv
// Serial frame transmitter: idle-high line, start bit, DATA_W data bits LSB first,
// then STOP_BITS stop bits. Defining FSMSERIAL_TX_PARITY_EN adds an odd-parity bit before the stop bits.
module fsmserial_tx #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              out,
  output logic              busy,
  output logic              done
);

  localparam int BCW = $clog2(DATA_W) + 1;
  localparam int SCW = $clog2(STOP_BITS) + 1;

  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_W - 1);
  localparam logic [SCW-1:0] STOP_LAST = SCW'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef FSMSERIAL_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]        state;
  logic [DATA_W-1:0] shift_reg;
  logic [BCW-1:0]    bit_cnt;
  logic [SCW-1:0]    stop_cnt;
  logic              out_r;
  logic              last_stop;
  logic              accept;
`ifdef FSMSERIAL_TX_PARITY_EN
  logic              par_r;
`endif

  assign last_stop = (state == STOP) && (stop_cnt == STOP_LAST);
  assign ready     = (state == IDLE) || last_stop;
  assign accept    = valid && ready;
  assign busy      = (state != IDLE);
  assign done      = last_stop;
  assign out       = out_r;

  // out_r is loaded with the value for the state being entered, so the line
  // lags the handshake by exactly one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= '0;
      out_r     <= 1'b1;
`ifdef FSMSERIAL_TX_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else if (accept) begin
      // Accept is only possible in IDLE or the last stop cycle; both start a frame.
      state     <= START;
      shift_reg <= data;
      out_r     <= 1'b0;
`ifdef FSMSERIAL_TX_PARITY_EN
      par_r     <= ~^data;
`endif
    end else begin
      case (state)
        IDLE: begin
          out_r <= 1'b1;
        end
        START: begin
          state     <= DATA;
          out_r     <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= '0;
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
`ifdef FSMSERIAL_TX_PARITY_EN
            state    <= PARITY;
            out_r    <= par_r;
`else
            state    <= STOP;
            out_r    <= 1'b1;
            stop_cnt <= '0;
`endif
          end else begin
            out_r     <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
`ifdef FSMSERIAL_TX_PARITY_EN
        PARITY: begin
          state    <= STOP;
          out_r    <= 1'b1;
          stop_cnt <= '0;
        end
`endif
        STOP: begin
          out_r <= 1'b1;
          if (last_stop) state <= IDLE;
          else           stop_cnt <= stop_cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          out_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsmserial_tx.sv
// Randomized bench for fsmserial_tx: two instances (8/1 and 5/2) checked every cycle
// against a queue of expected line bits built from the frame format.
module tb_fsmserial_tx;

`ifdef FSMSERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data8;
  logic       valid8, ready8, out8, busy8, done8;
  logic [4:0] data5;
  logic       valid5, ready5, out5, busy5, done5;

  fsmserial_tx #(.DATA_W(8), .STOP_BITS(1)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .data(data8), .valid(valid8),
    .ready(ready8), .out(out8), .busy(busy8), .done(done8)
  );

  fsmserial_tx #(.DATA_W(5), .STOP_BITS(2)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .data(data5), .valid(valid5),
    .ready(ready5), .out(out5), .busy(busy5), .done(done5)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Expected line values: front is the current cycle, the rest are future cycles.
  bit q8[$];
  bit q5[$];
  bit rec[$];
  bit rec_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_len(input int w, input int sb);
    return 1 + w + PAR + sb;
  endfunction

  function automatic bit frame_bit(input int w, input logic [15:0] d, input int i);
    logic [31:0] mask;
    mask = (32'h1 << w) - 32'h1;
    if (i == 0) return 1'b0;
    if (i <= w) return d[i-1];
    if (PAR == 1 && i == w + 1) return ~^(32'(d) & mask);
    return 1'b1;
  endfunction

  task automatic step(output bit a8, output bit a5);
    a8 = valid8 && (q8.size() <= 1);
    a5 = valid5 && (q5.size() <= 1);
    @(posedge clk);
    if (q8.size() > 0) void'(q8.pop_front());
    if (q5.size() > 0) void'(q5.pop_front());
    if (a8) for (int i = 0; i < frame_len(8, 1); i++) q8.push_back(frame_bit(8, 16'(data8), i));
    if (a5) for (int i = 0; i < frame_len(5, 2); i++) q5.push_back(frame_bit(5, 16'(data5), i));
    #1;
    check("out8",   out8,   (q8.size() > 0) ? q8[0] : 1'b1);
    check("ready8", ready8, q8.size() <= 1);
    check("busy8",  busy8,  q8.size() > 0);
    check("done8",  done8,  q8.size() == 1);
    check("out5",   out5,   (q5.size() > 0) ? q5[0] : 1'b1);
    check("ready5", ready5, q5.size() <= 1);
    check("busy5",  busy5,  q5.size() > 0);
    check("done5",  done5,  q5.size() == 1);
    if (rec_on) rec.push_back(out8);
  endtask

  initial begin
    bit a8, a5;
    bit got2;
    logic [7:0] w1, w2;
    int fl;

    reset_n = 1'b0;
    valid8 = 1'b0; data8 = '0;
    valid5 = 1'b0; data5 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out8",   out8,   1'b1);
    check("rst_ready8", ready8, 1'b1);
    check("rst_busy8",  busy8,  1'b0);
    check("rst_done8",  done8,  1'b0);
    @(negedge clk) reset_n = 1'b1;
    repeat (5) step(a8, a5);

    // Single frames: A5 on the 8-bit instance, 15 on the 5-bit/2-stop instance.
    data8 = 8'hA5; valid8 = 1'b1;
    data5 = 5'h15; valid5 = 1'b1;
    step(a8, a5);
    valid8 = 1'b0; valid5 = 1'b0;
    data8 = 8'h00; data5 = 5'h00;
    repeat (12) step(a8, a5);

    // Back-to-back with valid held high; decode the captured line like a receiver.
    rec.delete();
    rec_on = 1'b1;
    data8 = 8'h3C; valid8 = 1'b1;
    step(a8, a5);
    check("b2b_acc1", a8, 1'b1);
    data8 = 8'hFF;
    got2 = 1'b0;
    for (int i = 0; i < 20 && !got2; i++) begin
      step(a8, a5);
      got2 = a8;
    end
    check("b2b_acc2", got2, 1'b1);
    valid8 = 1'b0;
    repeat (12) step(a8, a5);
    rec_on = 1'b0;
    fl = frame_len(8, 1);
    check("rx_len_ok", rec.size() >= 2 * fl, 1'b1);
    if (rec.size() >= 2 * fl) begin
      for (int i = 0; i < 8; i++) begin
        w1[i] = rec[1 + i];
        w2[i] = rec[fl + 1 + i];
      end
      check("rx_start1", rec[0], 1'b0);
      check("rx_start2", rec[fl], 1'b0);
      check("rx_w1", w1, 8'h3C);
      check("rx_w2", w2, 8'hFF);
    end

    // Parity corner values (plain frames when parity is not built in).
    data8 = 8'h07; valid8 = 1'b1;
    step(a8, a5);
    data8 = 8'h03;
    for (int i = 0; i < 20 && !a8; i++) step(a8, a5);
    valid8 = 1'b0;
    repeat (14) step(a8, a5);

    // Asynchronous reset during data bit 4.
    data8 = 8'h5A; valid8 = 1'b1;
    data5 = 5'h0B; valid5 = 1'b1;
    step(a8, a5);
    valid8 = 1'b0; valid5 = 1'b0;
    repeat (5) step(a8, a5);
    #3 reset_n = 1'b0;
    #1;
    check("mid_out8",   out8,   1'b1);
    check("mid_busy8",  busy8,  1'b0);
    check("mid_ready8", ready8, 1'b1);
    check("mid_done8",  done8,  1'b0);
    check("mid_out5",   out5,   1'b1);
    check("mid_busy5",  busy5,  1'b0);
    q8.delete();
    q5.delete();
    @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) step(a8, a5);
    data8 = 8'h01; valid8 = 1'b1;
    step(a8, a5);
    valid8 = 1'b0;
    repeat (12) step(a8, a5);

    // Random traffic: upstream holds data until the handshake, valid toggles randomly.
    valid8 = 1'b1; data8 = 8'($urandom);
    valid5 = 1'b0; data5 = 5'($urandom);
    repeat (1500) begin
      step(a8, a5);
      if (a8) begin
        data8  = 8'($urandom);
        valid8 = ($urandom_range(0, 3) != 0);
      end else if (!valid8) begin
        data8  = 8'($urandom);
        valid8 = ($urandom_range(0, 2) == 0);
      end
      if (a5) begin
        data5  = 5'($urandom);
        valid5 = ($urandom_range(0, 3) != 0);
      end else if (!valid5) begin
        data5  = 5'($urandom);
        valid5 = ($urandom_range(0, 2) == 0);
      end
    end
    valid8 = 1'b0; valid5 = 1'b0;
    repeat (15) step(a8, a5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsmserial_tx.md
Name: fsmserial_tx

Overview:
- Serial byte transmitter for the single-wire, one-bit-per-clock framing protocol used by the serial receiver FSM: line idles high, then start bit (0), DATA_W data bits LSB first, then STOP_BITS stop bits (1).
- Takes parallel words over a valid/ready handshake, serializes them onto `out`, and signals frame completion.
- Sits upstream of the receiver; driving `out` directly into the receiver's `in` must produce a receiver `done` for every frame.

Parameters:
- DATA_W, 8, data bits per frame (legal range 1..16).
- STOP_BITS, 1, stop-bit cycles per frame (legal range 1..4).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- data  input  DATA_W  word to transmit
- valid  input  1  data is valid
- ready  output  1  transmitter can accept a word this cycle
- out  output  1  serial line (idle = 1)
- busy  output  1  frame in progress (START through final STOP)
- done  output  1  one-cycle pulse during the final stop-bit cycle of each frame

Behaviour:
- Reset (reset_n=0, takes effect immediately): state=IDLE, out=1, busy=0, done=0, ready=1. Shift register and counters are cleared.
- Reset mid-frame abandons the frame. `out` returns high at once; no done pulse.
- States: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- `out` is registered; it is 1 in IDLE/STOP, 0 in START, and shift_reg[0] in DATA.
- Accept: the handshake fires on a rising edge where valid && ready. `data` is latched into shift_reg; next state = START.
- Latency: accept at edge T. Then:
  - cycle T+1: out=0 (start)
  - cycles T+2..T+1+DATA_W: data[0]..data[DATA_W-1]
  - next STOP_BITS cycles: out=1
- Frame length is 1+DATA_W+STOP_BITS cycles (+1 with parity).
- DATA:
  - shift_reg shifts right one bit per cycle.
  - bit counter, width $clog2(DATA_W)+1, counts 0..DATA_W-1.
  - After the last bit, go to PARITY or STOP.
- STOP:
  - stop counter counts 0..STOP_BITS-1.
  - done=1 only in the last stop cycle.
- ready = (state==IDLE) || (state==STOP && last stop cycle).
  - Back-to-back: an accept in the last stop cycle goes directly to START, so there are no idle cycles between frames.
  - done and ready are both high in that cycle.
- From the last stop cycle with no accept, go to IDLE.
- Words presented while ready=0 are ignored. `valid` may stay high; the upstream must hold `data` until the handshake.
- busy=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Changes to `data` after acceptance have no effect on the frame in flight.

Optional Feature:
- Macro: FSMSERIAL_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, lasting one cycle.
  - out = ~^(accepted word), i.e. odd parity: data bits plus parity bit hold an odd number of 1s.
  - Parity is computed at accept time and held in a register.
  - Frame length is 2+DATA_W+STOP_BITS.
- When undefined: no PARITY state or parity register exists, and frame timing is as in Behaviour.

Test Plan:
- Reset idle: hold reset_n=0 for 3 cycles, release, wait 5 cycles -> out=1, ready=1, busy=0, done=0 throughout.
- Single frame: data=8'hA5, valid for one cycle at edge T -> out sequence from T+1 is 0,1,0,1,0,0,1,0,1,1; done=1 only at T+10; ready=1 again from T+10.
- Back-to-back: valid held high with 8'h3C then 8'hFF (second word presented while ready=0) -> second start bit at T+11, with no idle cycle. A receiver model returns 3C then FF.
- Async reset mid-frame: assert reset_n=0 during data bit 4, between clock edges -> out=1 and busy=0 before the next edge. After release, a new frame with 8'h01 transmits correctly.
- Parity (macro defined): data=8'h07 -> parity bit at T+10 = 0; stop at T+11 with done=1. data=8'h03 -> parity bit = 1.
- Parameter sweep: DATA_W=5, STOP_BITS=2, data=5'h15 -> out from T+1 is 0,1,0,1,0,1,1,1; done=1 at T+8 only.
